// File: rtl/time_pkg.sv
// Shared BCD types, time constants and the BCD range check used by the time-of-day counter.
package time_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam int        BCD_MAX_DIGIT = 9;
  localparam int        MINSEC_MOD    = 60;
  localparam bcd_pair_t MINSEC_MAX    = 8'h59;

  // True when both nibbles are decimal digits and the pair is below the modulus.
  function automatic logic bcd_pair_valid(input bcd_pair_t value, input int modulus);
    int tens;
    int units;
    tens  = int'(value[7:4]);
    units = int'(value[3:0]);
    return (tens <= BCD_MAX_DIGIT) && (units <= BCD_MAX_DIGIT) &&
           ((tens * 10 + units) < modulus);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter modulo MOD with parallel load and a registered wrap pulse.
module bcd_pair_counter
  import time_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      load,
  input  bcd_pair_t load_val,
  output bcd_pair_t value,
  output logic      wrap
);

  localparam bcd_digit_t TOP_TENS  = bcd_digit_t'((MOD - 1) / 10);
  localparam bcd_digit_t TOP_UNITS = bcd_digit_t'((MOD - 1) % 10);

  bcd_digit_t tens;
  bcd_digit_t units;

  assign tens  = value[7:4];
  assign units = value[3:0];

  // Load has priority; the wrap pulse accompanies the return to 00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        value <= load_val;
      end else if (inc) begin
        if (tens == TOP_TENS && units == TOP_UNITS) begin
          value <= '0;
          wrap  <= 1'b1;
        end else if (units == bcd_digit_t'(BCD_MAX_DIGIT)) begin
          value <= {tens + 4'd1, 4'd0};
        end else begin
          value <= {tens, units + 4'd1};
        end
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: synchronises the 1 Hz level, detects its rising edge and
// drives cascaded BCD second/minute/hour counters with a validated parallel load.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOURS_MOD   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sec_prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   sec_event;
  logic                   load_ok;
  logic                   accept_load;
  logic                   ss_inc;
  logic                   mm_inc;
  logic                   hh_inc;

  // Arming hides a sec_in that is already high when reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      sec_prev <= 1'b0;
      arm_cnt  <= '0;
      load_err <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sec_in};
      sec_prev <= sync_q[SYNC_STAGES-1];
      load_err <= load & ~load_ok;
      if (!armed) begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  assign armed     = (arm_cnt == ARM_W'(ARM_CYCLES));
  assign sec_event = armed & run & sync_q[SYNC_STAGES-1] & ~sec_prev;

  assign load_ok = bcd_pair_valid(load_hh, HOURS_MOD) &&
                   bcd_pair_valid(load_mm, MINSEC_MOD) &&
                   bcd_pair_valid(load_ss, MINSEC_MOD);
  assign accept_load = load & load_ok;

  // Any load request, accepted or not, swallows a coincident second.
  assign ss_inc = sec_event & ~load;
  assign mm_inc = ss_inc & (ss == MINSEC_MAX);
  assign hh_inc = mm_inc & (mm == MINSEC_MAX);

  bcd_pair_counter #(.MOD(MINSEC_MOD)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (ss_inc),
    .load     (accept_load),
    .load_val (load_ss),
    .value    (ss),
    .wrap     (min_tick)
  );

  bcd_pair_counter #(.MOD(MINSEC_MOD)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (mm_inc),
    .load     (accept_load),
    .load_val (load_mm),
    .value    (mm),
    .wrap     (hour_tick)
  );

  bcd_pair_counter #(.MOD(HOURS_MOD)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (hh_inc),
    .load     (accept_load),
    .load_val (load_hh),
    .value    (hh),
    .wrap     (day_tick)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: a seconds-of-day reference model queues the
// expected registered outputs each clock and a negedge monitor compares them.
module tb_bcd_time_counter;

  localparam int S   = 2;
  localparam int HM  = 24;
  localparam int DAY = HM * 3600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_in = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_hh = 8'h00;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;
  logic [7:0] hh, mm, ss;
  logic       min_tick, hour_tick, day_tick, load_err;

  bcd_time_counter #(.SYNC_STAGES(S), .HOURS_MOD(HM)) dut (
    .clk       (clk),
    .reset     (reset),
    .sec_in    (sec_in),
    .run       (run),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .day_tick  (day_tick),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [3:0] flags;
  } obs_t;

  obs_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  int   t_sec;
  int   edge_n;
  bit   hist[$];
  bit   evt;
  logic [3:0] flags;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int limit);
    return (int'(b[7:4]) <= 9) && (int'(b[3:0]) <= 9) && (bcd_val(b) < limit);
  endfunction

  function automatic obs_t make_obs(input int t, input logic [3:0] f);
    obs_t o;
    o.hh    = to_bcd(t / 3600);
    o.mm    = to_bcd((t / 60) % 60);
    o.ss    = to_bcd(t % 60);
    o.flags = f;
    return o;
  endfunction

  // Reference model: time as seconds-of-day, sec_in seen through an S-cycle delay line.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_sec  = 0;
      edge_n = 0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
      exp_q.delete();
      exp_q.push_back(make_obs(0, 4'b0000));
    end else begin
      edge_n++;
      hist.push_front(sec_in);
      void'(hist.pop_back());
      evt   = (edge_n >= S + 2) && hist[S] && !hist[S+1] && run;
      flags = 4'b0000;
      if (load) begin
        if (bcd_ok(load_hh, HM) && bcd_ok(load_mm, 60) && bcd_ok(load_ss, 60))
          t_sec = bcd_val(load_hh) * 3600 + bcd_val(load_mm) * 60 + bcd_val(load_ss);
        else
          flags[0] = 1'b1;
      end else if (evt) begin
        t_sec    = (t_sec + 1) % DAY;
        flags[3] = (t_sec % 60 == 0);
        flags[2] = (t_sec % 3600 == 0);
        flags[1] = (t_sec == 0);
      end
      exp_q.push_back(make_obs(t_sec, flags));
    end
  end

  task automatic check_output(input obs_t e);
    check_count++;
    if ({hh, mm, ss} === {e.hh, e.mm, e.ss}) pass_count++;
    else $display("[TB] FAIL time @%0t: got %h:%h:%h expected %h:%h:%h",
                  $time, hh, mm, ss, e.hh, e.mm, e.ss);
    check_count++;
    if ({min_tick, hour_tick, day_tick, load_err} === e.flags) pass_count++;
    else $display("[TB] FAIL flags @%0t: got min/hour/day/err=%b expected %b",
                  $time, {min_tick, hour_tick, day_tick, load_err}, e.flags);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hh = h;
    load_mm = m;
    load_ss = s;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  task automatic sec_pulse();
    sec_in = 1'b1;
    step(4);
    sec_in = 1'b0;
    step(4);
  endtask

  // Random square wave, run gaps and occasional loads, biased toward day rollover.
  task automatic apply_stimulus(input int cycles);
    int half;
    half = 4;
    for (int c = 0; c < cycles; c++) begin
      half--;
      if (half == 0) begin
        sec_in = ~sec_in;
        half   = $urandom_range(3, 6);
      end
      run  = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0: begin
          load_hh = to_bcd(HM - 1);
          load_mm = 8'h59;
          load_ss = to_bcd($urandom_range(50, 59));
        end
        1: begin
          load_hh = to_bcd($urandom_range(0, HM - 1));
          load_mm = to_bcd($urandom_range(0, 59));
          load_ss = to_bcd($urandom_range(0, 59));
        end
        default: begin
          load_hh = 8'($urandom);
          load_mm = 8'($urandom);
          load_ss = 8'($urandom);
        end
      endcase
      step(1);
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sec_in = 1'b1;
    run    = 1'b1;
    step(3);
    reset = 1'b1;
    step(10);
    sec_in = 1'b0;
    step(5);

    apply_load(8'h23, 8'h59, 8'h58);
    sec_pulse();
    sec_pulse();

    apply_load(8'h12, 8'h09, 8'h09);
    sec_pulse();
    apply_load(8'h12, 8'h59, 8'h59);
    sec_pulse();

    apply_load(8'h24, 8'h10, 8'h10);
    step(2);
    apply_load(8'h05, 8'h1A, 8'h10);
    step(2);
    apply_load(8'h05, 8'h10, 8'h60);
    step(2);

    apply_load(8'h00, 8'h00, 8'h05);
    run = 1'b0;
    sec_pulse();
    run = 1'b1;
    sec_in = 1'b1;
    step(S);
    apply_load(8'h08, 8'h00, 8'h00);
    step(3);
    sec_in = 1'b0;
    step(4);

    apply_load(8'h07, 8'h30, 8'h45);
    sec_pulse();
    sec_pulse();
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    sec_pulse();
    sec_pulse();
    sec_pulse();

    apply_stimulus(2000);
    step(5);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter that consumes the 1 Hz square wave produced by the cascaded BCD divider stage and keeps hours, minutes and seconds as two-digit BCD values for display logic. It synchronises and edge-detects the 1 Hz input, advances seconds/minutes/hours with carry, and accepts a validated parallel time load. All logic runs on the single system clock; the 1 Hz input is treated as a data level, never as a clock.

## Interface
- SYNC_STAGES, 2: flops in the sec_in synchroniser (minimum 2)
- HOURS_MOD, 24: hour modulus; hours count 00..HOURS_MOD-1 (legal 2..24)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- sec_in  in  1  1 Hz square wave from the divider; a rising edge is one second
- run  in  1  1 = count seconds, 0 = hold the time
- load  in  1  one-cycle request to load load_hh/load_mm/load_ss
- load_hh  in  8  BCD hours {tens, units}
- load_mm  in  8  BCD minutes
- load_ss  in  8  BCD seconds
- hh  out  8  BCD hours
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- min_tick  out  1  one-cycle pulse on ss 59->00
- hour_tick  out  1  one-cycle pulse on mm 59->00 with the carry
- day_tick  out  1  one-cycle pulse on hh (HOURS_MOD-1)->00 with the carry
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset (reset=0, asynchronous): hh=mm=ss=8'h00; min_tick, hour_tick, day_tick, load_err = 0; synchroniser and edge register = 0; arm counter = 0.
- Arming: after reset release, edge detection is disabled for SYNC_STAGES+1 cycles, so a sec_in already high at release is not counted.
- Second event: the synchronised sec_in is 1 and was 0 the previous cycle, detection is armed, and run=1. With run=0, edges are discarded, not queued.
- On a second event:
  - ss increments: units digit 9 -> 0 with a carry into tens; 59 -> 00 asserts min_tick and increments mm.
  - mm follows the same rule; 59 -> 00 asserts hour_tick and increments hh.
  - hh wraps from HOURS_MOD-1 to 00 and asserts day_tick.
  - All three digit pairs update in the same cycle, and the tick pulses coincide with that update.
- Load is valid only if every nibble is ≤9, ss≤59, mm≤59 and hh≤HOURS_MOD-1.
  - Valid: the time registers take the load values on the next edge; no ticks are generated.
  - Invalid: the time is unchanged and load_err pulses for one cycle.
- Load and a second event in the same cycle: load wins and that second is dropped. A rejected load also drops that second.
- The BCD registers never hold a non-BCD or out-of-range value.

## Timing
- Second-event latency: a sec_in rising edge is reflected in ss SYNC_STAGES+1 clk cycles later (3 at default).
- Load latency: the outputs show the loaded value 1 cycle after load=1.
- load_err latency: 1 cycle after load=1.
- All outputs are registered; the tick pulses are exactly one cycle wide.
- Minimum sec_in high and low times: SYNC_STAGES+1 cycles each. Shorter pulses may be missed; this is not checked.
- Reset asserted mid-count clears immediately and asynchronously. Release is expected synchronous to clk, followed by re-arming.

## Structure
- Shared package time_pkg: BCD digit/pair typedefs, the constants BCD_MAX_DIGIT=9 and MINSEC_MOD=60, and the function bcd_pair_valid(value, modulus).
- Sub-module bcd_pair_counter, instantiated three times. It has parameter MOD and:
  - inputs: inc, load, load_val
  - outputs: the value and a wrap pulse
- Synchroniser, edge detect, arming and load validation live in the top module.

## Test plan
- Reset with sec_in=1, release, hold sec_in high for 10 cycles, then drive it low -> ss stays 00, no ticks.
- Load 23:59:58, then two sec_in edges -> 23:59:59, then 00:00:00. min_tick, hour_tick and day_tick pulse together in the cycle ss shows 00.
- Load 12:09:09, then one edge -> 12:09:10, min_tick=0. Separately, load 12:59:59, then one edge -> 13:00:00 with min_tick and hour_tick, day_tick=0.
- Load hh=8'h24, mm=8'h1A and ss=8'h60 one at a time (other fields legal) -> load_err pulses once for each, time unchanged.
- Time 00:00:05: one edge with run=0 -> ss stays 05. Then load asserted in the same cycle as a detected edge -> the loaded value appears and the edge is not applied.
- Assert reset mid-count at 07:30:45 -> all outputs are 0 within the same cycle, and counting resumes only after re-arming.
